alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one ALU32/ALUCtrl-code datapath between two requesters, for example an execute stage and a branch-compare or address unit. Each requester issues an operation as operands plus a 4-bit ALU control code over a valid/ready handshake. The block grants requests round-robin, drives the shared ALU, registers the result and Zero flag, and returns them to the granted requester on a per-requester response handshake. It sits between the requesters and an unmodified ALU32 instance.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control code width (ALUCtrl encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_in0, req0_in1 / req1_in0, req1_in1  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control code
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes the result
- rsp0_out / rsp1_out  out  WIDTH  registered ALU result
- rsp0_zero / rsp1_zero  out  1  registered Zero flag
- alu_in0, alu_in1  out  WIDTH  to ALU32 in0/in1
- alu_ctrl  out  CTRL_W  to ALU32 ALUCtrl
- alu_out  in  WIDTH  from ALU32 ALUOut
- alu_zero  in  1  from ALU32 Zero

## Operation
- Single clock; reset is synchronous and active-low. All state updates on the rising clk edge. rst_n low at an edge forces reset state regardless of other inputs.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and asserted only for the winner. If only one valid, it wins. If both are valid, the requester indicated by prio wins (prio=0 selects req0).
  - On the accepting edge: latch the winner's in0, in1 and ctrl into op registers; set gnt to the winner index; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - alu_in0, alu_in1 and alu_ctrl are driven from the op registers. The ALU is combinational.
  - On the edge: capture alu_out and alu_zero into result registers; go to RESP. No req_ready is asserted.
- RESP:
  - rsp[gnt]_valid = 1. The other rsp_valid = 0.
  - When rsp[gnt]_ready = 1 on an edge: set prio to the non-granted index; go to IDLE.
  - Otherwise hold, with result and valid stable.
- rspN_out and rspN_zero both carry the shared result registers. They are meaningful only while rspN_valid is 1.
- alu_* outputs always reflect the op registers, so they are stable outside EXEC.
- Requester rule: a requester must keep valid and its operands stable until ready. The block does not check this.
- Unknown ctrl codes pass through unchanged. ALU behaviour for such codes is whatever ALU32 does.

## Timing
- Reset values:
  - State IDLE, prio=0, gnt=0.
  - Op and result registers 0.
  - rsp0_valid = rsp1_valid = 0.
  - req0_ready = req1_ready = 0 during and after reset until a request is present in IDLE.
  - alu_in0 = alu_in1 = 0, alu_ctrl = 0.
- Latency: request accepted at edge T → rsp_valid high from T+2 (after the EXEC edge at T+1).
- Throughput: a new request can be accepted in the cycle after the response handshake. Minimum 3 cycles per operation with rsp_ready tied high.
- Back-to-back contention with both valid and rsp_ready high: grants alternate req0, req1, req0, …
- A requester whose valid drops before ready is simply not granted. No state is kept for it.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is issued, and all outputs return to their reset values on that edge.
- Response back-pressure: rsp_valid and rsp_out stay constant for any number of cycles while rsp_ready = 0. No new request is accepted meanwhile.
- rsp_ready asserted while rsp_valid = 0 has no effect.

## Test plan
- Reset, then req0: in0=10, in1=20, ctrl=0010 (ADD), rsp0_ready=1 → req0_ready high in the first cycle; rsp0_valid high 2 cycles later with rsp0_out=30, rsp0_zero=0; rsp1_valid stays 0.
- req1: in0=10, in1=10, ctrl=0110 (SUB) → rsp1_out=0, rsp1_zero=1; then a BEQ-style SUB of 10 and 20 → rsp1_out=0xFFFFFFF6, zero=0.
- Both valid continuously after reset, with 4 ops queued per requester → grant order 0,1,0,1,0,1,0,1; every result matches its own operands; no grant is lost or duplicated.
- req0 ADD 5+7 with rsp0_ready held low for 5 cycles while req1 is valid → rsp0_valid=1 and rsp0_out=12 stable for all 5 cycles; req1_ready stays 0; req1 is granted in the cycle after the rsp0 handshake.
- rst_n low for one cycle while in EXEC, then in RESP, on separate runs → no rsp_valid pulse; all outputs at reset values; the next request completes normally with prio=0.
- ctrl=0000 (AND) 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0; ctrl=0001 (OR) on the same operands → 0xFFF0FFF0; alu_ctrl/alu_in* observed equal to the latched values during EXEC.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU32 between two
// requesters. Each operation is latched on acceptance, executed for one cycle
// on the shared ALU, and its result/Zero flag is held in registers until the
// granted requester consumes it.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_in0,
    input  logic [WIDTH-1:0]  req0_in1,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_in0,
    input  logic [WIDTH-1:0]  req1_in1,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_out,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_out,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_in0,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic                prio_r;
    logic                gnt_r;
    logic [WIDTH-1:0]    op_in0_r;
    logic [WIDTH-1:0]    op_in1_r;
    logic [CTRL_W-1:0]   op_ctrl_r;
    logic [WIDTH-1:0]    res_out_r;
    logic                res_zero_r;
    logic                rsp0_valid_r;
    logic                rsp1_valid_r;

    logic                accept_s;
    logic                win_s;
    logic [WIDTH-1:0]    win_in0_s;
    logic [WIDTH-1:0]    win_in1_s;
    logic [CTRL_W-1:0]   win_ctrl_s;
    logic                rsp_done_s;

    // Arbitration: pick the winner in IDLE; nothing is offered while reset is held.
    always_comb begin
        accept_s = 1'b0;
        win_s    = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
            if (req0_valid && req1_valid) begin
                accept_s = 1'b1;
                win_s    = prio_r;
            end else if (req0_valid) begin
                accept_s = 1'b1;
                win_s    = 1'b0;
            end else if (req1_valid) begin
                accept_s = 1'b1;
                win_s    = 1'b1;
            end else begin
                accept_s = 1'b0;
                win_s    = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            win_s    = 1'b0;
        end
    end

    // Operand select for the winning requester.
    always_comb begin
        win_in0_s  = {WIDTH{1'b0}};
        win_in1_s  = {WIDTH{1'b0}};
        win_ctrl_s = {CTRL_W{1'b0}};
        if (win_s) begin
            win_in0_s  = req1_in0;
            win_in1_s  = req1_in1;
            win_ctrl_s = req1_ctrl;
        end else begin
            win_in0_s  = req0_in0;
            win_in1_s  = req0_in1;
            win_ctrl_s = req0_ctrl;
        end
    end

    // Response handshake: only the granted requester's ready counts, only in RESP.
    always_comb begin
        rsp_done_s = 1'b0;
        if (state_r == RESP) begin
            rsp_done_s = gnt_r ? rsp1_ready : rsp0_ready;
        end else begin
            rsp_done_s = 1'b0;
        end
    end

    // Controller FSM with op, result and response-valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            prio_r       <= 1'b0;
            gnt_r        <= 1'b0;
            op_in0_r     <= {WIDTH{1'b0}};
            op_in1_r     <= {WIDTH{1'b0}};
            op_ctrl_r    <= {CTRL_W{1'b0}};
            res_out_r    <= {WIDTH{1'b0}};
            res_zero_r   <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_in0_r  <= win_in0_s;
                        op_in1_r  <= win_in1_s;
                        op_ctrl_r <= win_ctrl_s;
                        gnt_r     <= win_s;
                        state_r   <= EXEC;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                EXEC: begin
                    res_out_r    <= alu_out;
                    res_zero_r   <= alu_zero;
                    rsp0_valid_r <= ~gnt_r;
                    rsp1_valid_r <= gnt_r;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (rsp_done_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        prio_r       <= ~gnt_r;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= RESP;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = accept_s & ~win_s;
    assign req1_ready = accept_s & win_s;

    // The ALU always sees the latched operation, so its inputs never glitch
    // with requester activity.
    assign alu_in0  = op_in0_r;
    assign alu_in1  = op_in1_r;
    assign alu_ctrl = op_ctrl_r;

    // Both response channels carry the shared result; valid qualifies them.
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_out   = res_out_r;
    assign rsp1_out   = res_out_r;
    assign rsp0_zero  = res_zero_r;
    assign rsp1_zero  = res_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU32.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_in0, req0_in1, req1_in0, req1_in1;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_out, rsp1_out;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_in0, alu_in1, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in0(req0_in0), .req0_in1(req0_in1), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in0(req1_in0), .req1_in1(req1_in1), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the unmodified ALU32 (combinational).
    always_comb begin
        case (alu_ctrl)
            C_AND:   alu_out = alu_in0 & alu_in1;
            C_OR:    alu_out = alu_in0 | alu_in1;
            C_ADD:   alu_out = alu_in0 + alu_in1;
            C_SUB:   alu_out = alu_in0 - alu_in1;
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int r);
        return (r != 0) ? req1_ready : req0_ready;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        if (r != 0) begin
            req1_valid = 1'b1; req1_in0 = a; req1_in1 = b; req1_ctrl = c;
        end else begin
            req0_valid = 1'b1; req0_in0 = a; req0_in1 = b; req0_ctrl = c;
        end
    endtask

    // Bounded wait (at negedges) for requester r to be offered ready.
    task automatic wait_ready(input int r, input string tag);
        int n = 0;
        @(negedge clk);
        while (!rdy(r) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(rdy(r)), 32'd1);
    endtask

    // From an accepting cycle: accept, check EXEC view, check response, handshake.
    task automatic complete(input int r, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, input logic [31:0] eo, input logic ez,
                            input string tag);
        if (r != 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        if (r != 0) req1_valid = 1'b0; else req0_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_exec_in0"}, alu_in0, a);
        chk({tag, "_exec_in1"}, alu_in1, b);
        chk({tag, "_exec_ctrl"}, 32'(alu_ctrl), 32'(c));
        chk({tag, "_exec_novalid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk({tag, "_exec_noready"}, 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'({rsp1_valid, rsp0_valid}), (r != 0) ? 32'd2 : 32'd1);
        chk({tag, "_out"}, (r != 0) ? rsp1_out : rsp0_out, eo);
        chk({tag, "_zero"}, 32'((r != 0) ? rsp1_zero : rsp0_zero), 32'(ez));
        @(posedge clk);
        #1;
    endtask

    // Reset while an operation is in EXEC (in_resp=0) or RESP (in_resp=1).
    task automatic reset_mid(input bit in_resp, input string tag);
        do_reset();
        drive_req(0, 32'd3, 32'd4, C_ADD);
        wait_ready(0, {tag, "_pre_rdy"});
        complete(0, 32'd3, 32'd4, C_ADD, 32'd7, 1'b0, {tag, "_pre"});
        rsp0_ready = 1'b0;
        drive_req(0, 32'd9, 32'd9, C_SUB);
        wait_ready(0, {tag, "_op_rdy"});
        @(posedge clk);
        #1 req0_valid = 1'b0;
        if (in_resp) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({tag, "_in_resp"}, 32'(rsp0_valid), 32'd1);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk({tag, "_rst_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
            chk({tag, "_rst_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
            chk({tag, "_rst_in0"}, alu_in0, 32'd0);
            chk({tag, "_rst_in1"}, alu_in1, 32'd0);
            chk({tag, "_rst_ctrl"}, 32'(alu_ctrl), 32'd0);
            chk({tag, "_rst_out"}, rsp0_out, 32'd0);
        end
        @(posedge clk);
        #1;
        drive_req(0, 32'd6, 32'd2, C_SUB);
        drive_req(1, 32'd1, 32'd1, C_ADD);
        @(negedge clk);
        chk({tag, "_prio0"}, 32'({req1_ready, req0_ready}), 32'd1);
        complete(0, 32'd6, 32'd2, C_SUB, 32'd4, 1'b0, {tag, "_post"});
        req1_valid = 1'b0;
    endtask

    logic [31:0] r0_a [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] r0_b [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [31:0] r0_e [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
    logic [31:0] r1_a [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
    logic [31:0] r1_b [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] r1_e [4] = '{32'd99, 32'd198, 32'd297, 32'd396};

    initial begin
        int i0, i1, g, n;
        req0_in0 = 32'd0; req0_in1 = 32'd0; req0_ctrl = 4'd0;
        req1_in0 = 32'd0; req1_in1 = 32'd0; req1_ctrl = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0; req1_valid = 1'b0;

        // Reset state, with a request pending during reset.
        rst_n = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_alu_in0", alu_in0, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req0_valid = 1'b0;

        // Single-requester ADD, then SUBs on req1, then AND/OR.
        drive_req(0, 32'd10, 32'd20, C_ADD);
        @(negedge clk);
        chk("add_ready_first", 32'({req1_ready, req0_ready}), 32'd1);
        complete(0, 32'd10, 32'd20, C_ADD, 32'd30, 1'b0, "add");
        drive_req(1, 32'd10, 32'd10, C_SUB);
        wait_ready(1, "sub_eq_rdy");
        complete(1, 32'd10, 32'd10, C_SUB, 32'd0, 1'b1, "sub_eq");
        drive_req(1, 32'd10, 32'd20, C_SUB);
        wait_ready(1, "sub_ne_rdy");
        complete(1, 32'd10, 32'd20, C_SUB, 32'hFFFF_FFF6, 1'b0, "sub_ne");
        drive_req(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, C_AND);
        wait_ready(0, "and_rdy");
        complete(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, C_AND, 32'h00F0_00F0, 1'b0, "and");
        drive_req(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, C_OR);
        wait_ready(0, "or_rdy");
        complete(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, C_OR, 32'hFFF0_FFF0, 1'b0, "or");

        // Contention: both valid with 4 ops each; grants must alternate from req0.
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        i0 = 0; i1 = 0;
        drive_req(0, r0_a[0], r0_b[0], C_ADD);
        drive_req(1, r1_a[0], r1_b[0], C_SUB);
        for (int k = 0; k < 8; k++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("cont_grant", 32'({req1_ready, req0_ready}), (k % 2 != 0) ? 32'd2 : 32'd1);
            g = req1_ready ? 1 : 0;
            @(posedge clk);
            #1;
            if (g != 0) begin
                i1++;
                if (i1 < 4) drive_req(1, r1_a[i1], r1_b[i1], C_SUB); else req1_valid = 1'b0;
            end else begin
                i0++;
                if (i0 < 4) drive_req(0, r0_a[i0], r0_b[i0], C_ADD); else req0_valid = 1'b0;
            end
            @(negedge clk);
            @(negedge clk);
            chk("cont_valid", 32'({rsp1_valid, rsp0_valid}), (g != 0) ? 32'd2 : 32'd1);
            chk("cont_out", (g != 0) ? rsp1_out : rsp0_out,
                (g != 0) ? r1_e[(i1 > 0) ? i1 - 1 : 0] : r0_e[(i0 > 0) ? i0 - 1 : 0]);
            @(posedge clk);
            #1;
        end
        chk("cont_count0", 32'(i0), 32'd4);
        chk("cont_count1", 32'(i1), 32'd4);

        // Response back-pressure with req1 waiting.
        do_reset();
        rsp1_ready = 1'b1;
        drive_req(0, 32'd5, 32'd7, C_ADD);
        drive_req(1, 32'd3, 32'd1, C_AND);
        @(negedge clk);
        chk("bp_grant0", 32'({req1_ready, req0_ready}), 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_exec_ready", 32'(req1_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd1);
            chk("bp_out", rsp0_out, 32'd12);
            chk("bp_r1_ready", 32'(req1_ready), 32'd0);
        end
        rsp0_ready = 1'b1;
        @(posedge clk);
        #1 rsp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_r1_next", 32'({req1_ready, req0_ready}), 32'd2);
        complete(1, 32'd3, 32'd1, C_AND, 32'd1, 1'b0, "bp_r1");

        // Reset in EXEC, then in RESP.
        reset_mid(1'b0, "rexec");
        reset_mid(1'b1, "rresp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
